key_entry_ctrl: RTL and testbench

KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

---
 rtl/key_entry_ctrl.sv | 110 +++++++++++
 tb/tb_key_entry_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: collects BCD digits from a debounced scanner,
// supports backspace/clear/enter, and hands the committed value to a consumer.
module key_entry_ctrl #(
  parameter int          DIGITS  = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_en,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [2:0]            digit_cnt,
  output logic [4*DIGITS-1:0]   out_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int          W          = 4 * DIGITS;
  localparam logic [2:0]  MAX_CNT    = 3'(DIGITS);
  localparam logic [15:0] IDLE_LIMIT = TIMEOUT - 16'd1;

  localparam logic [3:0] KEY_BKSP  = 4'd10;
  localparam logic [3:0] KEY_CLR   = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

  state_t         state;
  logic           key_en_d;
  logic [W-1:0]   buffer;
  logic [15:0]    idle_cnt;
  logic           key_event;
  logic           is_digit;

  assign key_event = key_en & ~key_en_d;
  assign is_digit  = (key_code <= 4'd9);
  assign disp_bcd  = buffer;

  // A key event always takes priority over the idle timeout on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_en_d  <= 1'b0;
      buffer    <= '0;
      digit_cnt <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      key_en_d <= key_en;
      err      <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (key_event) begin
            idle_cnt <= '0;
            if (is_digit) begin
              if (digit_cnt < MAX_CNT) begin
                buffer    <= {buffer[W-5:0], key_code};
                digit_cnt <= digit_cnt + 3'd1;
                state     <= ENTRY;
              end else begin
                err <= 1'b1;
              end
            end else if (key_code == KEY_BKSP) begin
              if (state == ENTRY) begin
                buffer    <= {4'h0, buffer[W-1:4]};
                digit_cnt <= digit_cnt - 3'd1;
                if (digit_cnt == 3'd1) state <= IDLE;
              end
            end else if (key_code == KEY_CLR) begin
              buffer    <= '0;
              digit_cnt <= '0;
              state     <= IDLE;
            end else if (key_code == KEY_ENTER) begin
              if (state == ENTRY) begin
                out_value <= buffer;
                out_valid <= 1'b1;
                state     <= HOLD;
              end else begin
                err <= 1'b1;
              end
            end
          end else if (state == ENTRY) begin
            if (idle_cnt == IDLE_LIMIT) begin
              buffer    <= '0;
              digit_cnt <= '0;
              idle_cnt  <= '0;
              state     <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            buffer    <= '0;
            digit_cnt <= '0;
            idle_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: per-cycle vector table plus
// hand-written sequences for held keys, timeout and reset corner cases.
module tb_key_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_en;
  logic [3:0]  key_code;
  logic        out_ready;

  logic [15:0] disp_bcd, out_value;
  logic [2:0]  digit_cnt;
  logic        out_valid, err;

  logic [15:0] t_disp_bcd, t_out_value;
  logic [2:0]  t_digit_cnt;
  logic        t_out_valid, t_err;

  int n_checks = 0;
  int n_fail   = 0;

  key_entry_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_en(key_en), .key_code(key_code),
    .disp_bcd(disp_bcd), .digit_cnt(digit_cnt), .out_value(out_value),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  // Short-timeout instance used for the auto-clear sequences.
  key_entry_ctrl #(.DIGITS(4), .TIMEOUT(16'd10)) dut_t (
    .clk(clk), .rst_n(rst_n), .key_en(key_en), .key_code(key_code),
    .disp_bcd(t_disp_bcd), .digit_cnt(t_digit_cnt), .out_value(t_out_value),
    .out_valid(t_out_valid), .out_ready(out_ready), .err(t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        key_en;
    logic [3:0]  key_code;
    logic        out_ready;
    logic [15:0] disp;
    logic [2:0]  cnt;
    logic        valid;
    logic [15:0] value;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic en, input logic [3:0] code, input logic rdy,
                        input logic [15:0] disp, input logic [2:0] cnt,
                        input logic valid, input logic [15:0] value, input logic e);
    vec_t v;
    v.key_en = en; v.key_code = code; v.out_ready = rdy;
    v.disp = disp; v.cnt = cnt; v.valid = valid; v.value = value; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock, check at the next negedge.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    key_en    = v.key_en;
    key_code  = v.key_code;
    out_ready = v.out_ready;
    @(negedge clk);
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, ".disp"},  32'(disp_bcd),  32'(v.disp));
    checkOutput({tag, ".cnt"},   32'(digit_cnt), 32'(v.cnt));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v.valid));
    checkOutput({tag, ".value"}, 32'(out_value), 32'(v.value));
    checkOutput({tag, ".err"},   32'(err),       32'(v.err));
  endtask

  initial begin
    rst_n = 1'b0; key_en = 1'b0; key_code = 4'd0; out_ready = 1'b0;

    // 1,2,3, enter with consumer stalled, ignored key in HOLD, then accept
    addVec(1, 4'd1,  0, 16'h0001, 3'd1, 0, 16'h0000, 0);
    addVec(0, 4'd0,  0, 16'h0001, 3'd1, 0, 16'h0000, 0);
    addVec(1, 4'd2,  0, 16'h0012, 3'd2, 0, 16'h0000, 0);
    addVec(0, 4'd0,  0, 16'h0012, 3'd2, 0, 16'h0000, 0);
    addVec(1, 4'd3,  0, 16'h0123, 3'd3, 0, 16'h0000, 0);
    addVec(0, 4'd0,  0, 16'h0123, 3'd3, 0, 16'h0000, 0);
    addVec(1, 4'd12, 0, 16'h0123, 3'd3, 1, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0123, 3'd3, 1, 16'h0123, 0);
    addVec(1, 4'd5,  0, 16'h0123, 3'd3, 1, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0123, 3'd3, 1, 16'h0123, 0);
    addVec(1, 4'd12, 0, 16'h0123, 3'd3, 1, 16'h0123, 0);
    addVec(0, 4'd0,  1, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    // overflow: 9,8,7,6,5
    addVec(1, 4'd9,  0, 16'h0009, 3'd1, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0009, 3'd1, 0, 16'h0123, 0);
    addVec(1, 4'd8,  0, 16'h0098, 3'd2, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0098, 3'd2, 0, 16'h0123, 0);
    addVec(1, 4'd7,  0, 16'h0987, 3'd3, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0987, 3'd3, 0, 16'h0123, 0);
    addVec(1, 4'd6,  0, 16'h9876, 3'd4, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h9876, 3'd4, 0, 16'h0123, 0);
    addVec(1, 4'd5,  0, 16'h9876, 3'd4, 0, 16'h0123, 1);
    addVec(0, 4'd0,  0, 16'h9876, 3'd4, 0, 16'h0123, 0);
    addVec(1, 4'd11, 0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    // 4,5, backspace x3
    addVec(1, 4'd4,  0, 16'h0004, 3'd1, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0004, 3'd1, 0, 16'h0123, 0);
    addVec(1, 4'd5,  0, 16'h0045, 3'd2, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0045, 3'd2, 0, 16'h0123, 0);
    addVec(1, 4'd10, 0, 16'h0004, 3'd1, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0004, 3'd1, 0, 16'h0123, 0);
    addVec(1, 4'd10, 0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(1, 4'd10, 0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    // enter on empty buffer, reserved codes, out_ready while not valid
    addVec(1, 4'd12, 0, 16'h0000, 3'd0, 0, 16'h0123, 1);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(1, 4'd14, 0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(1, 4'd3,  0, 16'h0003, 3'd1, 0, 16'h0123, 0);
    addVec(0, 4'd0,  1, 16'h0003, 3'd1, 0, 16'h0123, 0);
    addVec(1, 4'd13, 0, 16'h0003, 3'd1, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0003, 3'd1, 0, 16'h0123, 0);
    addVec(1, 4'd11, 0, 16'h0000, 3'd0, 0, 16'h0123, 0);
    addVec(0, 4'd0,  0, 16'h0000, 3'd0, 0, 16'h0123, 0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset.disp",  32'(disp_bcd),  32'h0);
    checkOutput("reset.cnt",   32'(digit_cnt), 32'h0);
    checkOutput("reset.valid", 32'(out_valid), 32'h0);
    checkOutput("reset.value", 32'(out_value), 32'h0);
    checkOutput("reset.err",   32'(err),       32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Key held for 100 cycles produces a single digit
    key_en = 1'b1; key_code = 4'd7;
    repeat (100) @(negedge clk);
    checkOutput("held.cnt",  32'(digit_cnt), 32'd1);
    checkOutput("held.disp", 32'(disp_bcd),  32'h0007);
    key_en = 1'b0;
    @(negedge clk);

    // Reset asserted during HOLD takes effect without a clock edge
    key_en = 1'b1; key_code = 4'd12;
    @(negedge clk);
    key_en = 1'b0;
    @(negedge clk);
    checkOutput("hold.valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_hold.valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold.cnt",   32'(digit_cnt), 32'd0);
    checkOutput("rst_hold.disp",  32'(disp_bcd),  32'h0);

    // Key already high at reset release registers on the first edge
    @(negedge clk);
    key_en = 1'b1; key_code = 4'd6;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel.cnt",  32'(digit_cnt), 32'd1);
    checkOutput("rel.disp", 32'(disp_bcd),  32'h0006);
    key_en = 1'b0;
    @(negedge clk);

    // Timeout: buffer clears exactly 10 edges after the event edge
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    key_en = 1'b1; key_code = 4'd3;
    @(posedge clk);
    #1 key_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("tmo.e%0d.cnt", i), 32'(t_digit_cnt), 32'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("tmo.e10.cnt",  32'(t_digit_cnt), 32'd0);
    checkOutput("tmo.e10.disp", 32'(t_disp_bcd),  32'h0);

    // A digit on the 10th edge cancels the clear and restarts the count
    key_en = 1'b1; key_code = 4'd3;
    @(posedge clk);
    #1 key_en = 1'b0;
    repeat (9) @(posedge clk);
    #1 key_en = 1'b1; key_code = 4'd4;
    @(posedge clk);
    #1 key_en = 1'b0;
    checkOutput("cancel.cnt",  32'(t_digit_cnt), 32'd2);
    checkOutput("cancel.disp", 32'(t_disp_bcd),  32'h0034);
    repeat (9) @(posedge clk);
    #1 checkOutput("cancel.e9.cnt", 32'(t_digit_cnt), 32'd2);
    @(posedge clk);
    #1 checkOutput("cancel.e10.cnt", 32'(t_digit_cnt), 32'd0);
    checkOutput("cancel.err", 32'(t_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
